// File: rtl/ms_ctrl.sv
`timescale 1ns/1ps
// ms_ctrl: minesweeper game sequencer (generator restart, action arbitration, neighbour count).
// Latency: reveal handshake -> rev_valid 9 cycles later (8-cycle scan + 1 reveal cycle).
// Backpressure: act_ready drops outside PLAY; actions are only taken on act_valid & act_ready.
module ms_ctrl #(
  parameter int MINES     = 9,
  parameter int ROWS_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_game,
  input  logic        gen_done,
  input  logic [63:0] mine,
  output logic        gen_reset,
  input  logic        act_valid,
  output logic        act_ready,
  input  logic        act_type,
  input  logic [5:0]  act_pos,
  output logic [63:0] revealed,
  output logic [63:0] flagged,
  output logic        rev_valid,
  output logic [5:0]  rev_pos,
  output logic [3:0]  rev_cnt,
  output logic        playing,
  output logic        won,
  output logic        lost
);

  localparam int         CELLS   = 1 << (2 * ROWS_LOG2);
  localparam logic [6:0] WIN_CNT = 7'(CELLS - MINES);

  typedef enum logic [2:0] {
    IDLE, GEN_RST, GEN_WAIT, PLAY, SCAN, REVEAL, WIN, LOSE
  } state_t;

  state_t      state;
  logic [63:0] board;
  logic [5:0]  pos;
  logic [2:0]  k;
  logic [3:0]  acc;
  logic [1:0]  gen_cnt;
  logic [6:0]  rcnt;

  logic [3:0]  dr, dc, nr, nc;
  logic        nb_mine;
  logic [3:0]  acc_next;
  logic [6:0]  rcnt_inc;

  // Neighbour k of the latched cell; bit 3 of the 4-bit row/col sum flags -1 or 8, i.e. off-board.
  always_comb begin
    dr = 4'd0;
    dc = 4'd0;
    case (k)
      3'd0: begin dr = 4'hF; dc = 4'hF; end
      3'd1: begin dr = 4'hF; dc = 4'h0; end
      3'd2: begin dr = 4'hF; dc = 4'h1; end
      3'd3: begin dr = 4'h0; dc = 4'hF; end
      3'd4: begin dr = 4'h0; dc = 4'h1; end
      3'd5: begin dr = 4'h1; dc = 4'hF; end
      3'd6: begin dr = 4'h1; dc = 4'h0; end
      default: begin dr = 4'h1; dc = 4'h1; end
    endcase
    nr       = {1'b0, pos[5:3]} + dr;
    nc       = {1'b0, pos[2:0]} + dc;
    nb_mine  = ~nr[3] & ~nc[3] & board[{nr[2:0], nc[2:0]}];
    acc_next = acc + {3'b000, nb_mine};
    rcnt_inc = rcnt + 7'd1;
  end

  // Game FSM; every output is a register written on the transition into the state that owns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      board     <= '0;
      revealed  <= '0;
      flagged   <= '0;
      pos       <= '0;
      k         <= '0;
      acc       <= '0;
      gen_cnt   <= '0;
      rcnt      <= '0;
      rev_pos   <= '0;
      rev_cnt   <= '0;
      gen_reset <= 1'b0;
      act_ready <= 1'b0;
      rev_valid <= 1'b0;
      playing   <= 1'b0;
      won       <= 1'b0;
      lost      <= 1'b0;
    end else begin
      gen_reset <= 1'b0;
      rev_valid <= 1'b0;
      case (state)
        IDLE, WIN, LOSE: begin
          if (new_game) begin
            state     <= GEN_RST;
            gen_reset <= 1'b1;
            won       <= 1'b0;
            lost      <= 1'b0;
          end
        end
        GEN_RST: begin
          revealed <= '0;
          flagged  <= '0;
          rcnt     <= '0;
          gen_cnt  <= '0;
          state    <= GEN_WAIT;
        end
        GEN_WAIT: begin
          // the first two cycles ignore gen_done so a level left over from the last game is not taken
          if (gen_cnt != 2'd2) begin
            gen_cnt <= gen_cnt + 2'd1;
          end else if (gen_done) begin
            board     <= mine;
            state     <= PLAY;
            act_ready <= 1'b1;
            playing   <= 1'b1;
          end
        end
        PLAY: begin
          if (new_game) begin
            state     <= GEN_RST;
            gen_reset <= 1'b1;
            act_ready <= 1'b0;
            playing   <= 1'b0;
          end else if (act_valid) begin
            pos <= act_pos;
            if (act_type) begin
              if (!revealed[act_pos]) flagged[act_pos] <= ~flagged[act_pos];
            end else if (!flagged[act_pos] && !revealed[act_pos]) begin
              act_ready <= 1'b0;
              if (board[act_pos]) begin
                revealed[act_pos] <= 1'b1;
                state             <= LOSE;
                playing           <= 1'b0;
                lost              <= 1'b1;
              end else begin
                acc   <= '0;
                k     <= '0;
                state <= SCAN;
              end
            end
          end
        end
        SCAN: begin
          acc <= acc_next;
          k   <= k + 3'd1;
          if (k == 3'd7) begin
            state     <= REVEAL;
            rev_valid <= 1'b1;
            rev_pos   <= pos;
            rev_cnt   <= acc_next;
          end
        end
        REVEAL: begin
          revealed[pos] <= 1'b1;
          rcnt          <= rcnt_inc;
          if (rcnt_inc == WIN_CNT) begin
            state   <= WIN;
            playing <= 1'b0;
            won     <= 1'b1;
          end else begin
            state     <= PLAY;
            act_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_ctrl.sv
`timescale 1ns/1ps
// tb_ms_ctrl: directed stimulus for the minesweeper sequencer with hand-computed expectations.
// Latency: inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: actions are only presented while the controller sits in PLAY.
module tb_ms_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_game;
  logic        gen_done;
  logic [63:0] mine;
  logic        gen_reset;
  logic        act_valid;
  logic        act_ready;
  logic        act_type;
  logic [5:0]  act_pos;
  logic [63:0] revealed;
  logic [63:0] flagged;
  logic        rev_valid;
  logic [5:0]  rev_pos;
  logic [3:0]  rev_cnt;
  logic        playing;
  logic        won;
  logic        lost;

  int checks   = 0;
  int failures = 0;

  ms_ctrl #(.MINES(9), .ROWS_LOG2(3)) dut (
    .clk(clk), .reset(reset), .new_game(new_game), .gen_done(gen_done), .mine(mine),
    .gen_reset(gen_reset), .act_valid(act_valid), .act_ready(act_ready),
    .act_type(act_type), .act_pos(act_pos), .revealed(revealed), .flagged(flagged),
    .rev_valid(rev_valid), .rev_pos(rev_pos), .rev_cnt(rev_cnt),
    .playing(playing), .won(won), .lost(lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [63:0] m);
    int n;
    n        = 0;
    new_game = 1'b1;
    mine     = m;
    gen_done = 1'b1;
    step();
    new_game = 1'b0;
    while (!playing && n < 20) begin
      step();
      n++;
    end
    chk("start_playing", playing, 64'd1);
  endtask

  task automatic act(input logic t, input logic [5:0] p);
    act_valid = 1'b1;
    act_type  = t;
    act_pos   = p;
    step();
    act_valid = 1'b0;
  endtask

  // Handshake in cycle c; rev_valid expected exactly in c+9, revealed bit and act_ready in c+10.
  task automatic reveal(input string tag, input logic [5:0] p, input logic [3:0] exp_cnt,
                        input bit full);
    act(1'b0, p);
    repeat (7) step();
    if (full) chk({tag, "_early"}, rev_valid, 64'd0);
    step();
    chk({tag, "_rev_valid"}, rev_valid, 64'd1);
    if (full) begin
      chk({tag, "_rev_pos"}, rev_pos, 64'(p));
      chk({tag, "_rev_cnt"}, rev_cnt, 64'(exp_cnt));
    end
    step();
    if (full) begin
      chk({tag, "_revealed"}, revealed[p], 64'd1);
      chk({tag, "_ready"}, act_ready, 64'd1);
    end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog expired checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset     = 1'b0;
    new_game  = 1'b0;
    gen_done  = 1'b0;
    mine      = '0;
    act_valid = 1'b0;
    act_type  = 1'b0;
    act_pos   = '0;
    step();
    step();
    chk("rst_revealed", revealed, 64'd0);
    chk("rst_flagged", flagged, 64'd0);
    chk("rst_gen_reset", gen_reset, 64'd0);
    chk("rst_act_ready", act_ready, 64'd0);
    chk("rst_rev_valid", rev_valid, 64'd0);
    chk("rst_rev_pos", rev_pos, 64'd0);
    chk("rst_rev_cnt", rev_cnt, 64'd0);
    chk("rst_status", {playing, won, lost}, 64'd0);
    reset = 1'b1;
    step();

    // new game with a stale gen_done already high: one-cycle gen_reset, two ignored wait cycles
    gen_done = 1'b1;
    mine     = 64'h0000_0000_0000_0302;
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    chk("gen_reset_on", gen_reset, 64'd1);
    step();
    chk("gen_reset_off", gen_reset, 64'd0);
    chk("wait0_playing", playing, 64'd0);
    step();
    chk("wait1_playing", playing, 64'd0);
    step();
    chk("wait2_playing", playing, 64'd0);
    chk("wait2_ready", act_ready, 64'd0);
    step();
    chk("play_playing", playing, 64'd1);
    chk("play_ready", act_ready, 64'd1);

    // mines {1,8,9}: corner cell 0 sees all three
    reveal("r0", 6'd0, 4'd3, 1'b1);

    // corner mines {0,7,56,63}: no wrap-around across row or board edges
    start_game(64'h8100_0000_0000_0081);
    reveal("r9", 6'd9, 4'd1, 1'b1);
    reveal("r62", 6'd62, 4'd1, 1'b1);
    reveal("r8", 6'd8, 4'd1, 1'b1);
    reveal("r15", 6'd15, 4'd1, 1'b1);

    // cell 27 fully surrounded by mines
    start_game(64'h0000_001C_141C_0000);
    reveal("r27", 6'd27, 4'd8, 1'b1);

    // flag handling
    act(1'b1, 6'd5);
    chk("flag5_set", flagged, 64'h0000_0000_0000_0020);
    act(1'b0, 6'd5);
    chk("rev_flagged_ready", act_ready, 64'd1);
    chk("rev_flagged_revealed", revealed, 64'h0000_0000_0800_0000);
    act(1'b1, 6'd5);
    chk("flag5_clear", flagged, 64'd0);
    act(1'b1, 6'd27);
    chk("flag_revealed_ignored", flagged, 64'd0);
    act(1'b1, 6'd40);
    chk("flag40_set", flagged, 64'h0000_0100_0000_0000);

    // step on mine 18
    act(1'b0, 6'd18);
    chk("lose_lost", lost, 64'd1);
    chk("lose_revealed", revealed, 64'h0000_0000_0804_0000);
    chk("lose_ready", act_ready, 64'd0);
    chk("lose_playing", playing, 64'd0);
    chk("lose_rev_valid", rev_valid, 64'd0);
    seen = 1'b0;
    repeat (10) begin
      step();
      if (rev_valid) seen = 1'b1;
    end
    chk("lose_no_rev_valid", seen, 64'd0);
    chk("lose_flag_held", flagged, 64'h0000_0100_0000_0000);

    // restart clears bitmaps; mines on cells 0..8 leave 55 safe cells
    start_game(64'h0000_0000_0000_01FF);
    chk("restart_revealed", revealed, 64'd0);
    chk("restart_flagged", flagged, 64'd0);
    chk("restart_lost", lost, 64'd0);
    for (int p = 9; p < 63; p++) reveal("win_seq", 6'(p), 4'd4, (p == 9));
    chk("won_before_last", won, 64'd0);
    reveal("win_last", 6'd63, 4'd0, 1'b0);
    chk("won", won, 64'd1);
    chk("won_ready", act_ready, 64'd0);
    chk("won_playing", playing, 64'd0);

    // new_game beats a same-cycle action in PLAY
    start_game(64'h0000_0000_0000_0302);
    new_game  = 1'b1;
    act_valid = 1'b1;
    act_type  = 1'b0;
    act_pos   = 6'd0;
    step();
    new_game  = 1'b0;
    act_valid = 1'b0;
    chk("prio_gen_reset", gen_reset, 64'd1);
    chk("prio_ready", act_ready, 64'd0);
    seen = 1'b0;
    repeat (12) begin
      step();
      if (rev_valid) seen = 1'b1;
    end
    chk("prio_dropped", seen, 64'd0);
    chk("prio_playing", playing, 64'd1);

    // async reset in the middle of a scan
    act(1'b1, 6'd10);
    act(1'b0, 6'd0);
    repeat (3) step();
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_flagged", flagged, 64'd0);
    chk("mid_rst_status", {playing, won, lost, act_ready}, 64'd0);
    #3;
    reset = 1'b1;
    seen  = 1'b0;
    repeat (10) begin
      step();
      if (rev_valid) seen = 1'b1;
    end
    chk("mid_rst_no_reveal", seen, 64'd0);
    chk("mid_rst_idle", playing, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ms_ctrl.md
Name: ms_ctrl

Overview:
Game-sequencing controller for the 8x8 minesweeper board. It restarts the mine pool generator and waits for it to finish, then latches the mine map. It arbitrates player actions (reveal / flag toggle) through a valid/ready handshake and computes each revealed cell's adjacent-mine count by a sequential 8-neighbour scan. It also tracks the revealed/flagged bitmaps and reports win/lose. It sits between the input/cursor logic and the display, and drives the generator's synchronous reset.

Parameters:
MINES, 9, number of mines the generator places; win when revealed cells reach 64-MINES
ROWS_LOG2, 3, row field width of a position (fixed 8x8 board; not to be overridden)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
new_game  in  1  single-cycle request to start a new game
gen_done  in  1  generator finished flag (level)
mine  in  64  generator mine map, bit index = position
gen_reset  out  1  synchronous active-high reset pulse to the generator
act_valid  in  1  player action request
act_ready  out  1  controller can accept an action
act_type  in  1  0 = reveal, 1 = flag toggle
act_pos  in  6  cell position, [5:3] row, [2:0] col
revealed  out  64  revealed bitmap
flagged  out  64  flagged bitmap
rev_valid  out  1  one-cycle strobe: a cell was revealed
rev_pos  out  6  position of revealed cell (valid with rev_valid)
rev_cnt  out  4  adjacent-mine count 0..8 (valid with rev_valid)
playing / won / lost  out  1 each  game status, mutually exclusive

Behaviour:
- Reset (reset=0, async): state IDLE. revealed, flagged, board, rev_pos, rev_cnt, and revealed-counter all 0. gen_reset, act_ready, rev_valid, playing, won, lost all 0.
- States: IDLE, GEN_RST, GEN_WAIT, PLAY, SCAN, REVEAL, WIN, LOSE. All outputs are registered/Moore.
- new_game is honoured in IDLE, PLAY, WIN, LOSE -> GEN_RST. In PLAY it takes priority over a same-cycle act_valid, and that action is not accepted. It is ignored in GEN_RST, GEN_WAIT, SCAN, REVEAL.
- GEN_RST (1 cycle): gen_reset=1. Clear revealed, flagged, revealed-counter. -> GEN_WAIT.
- GEN_WAIT: gen_done is ignored for the first 2 cycles (guards against a stale done). Afterwards gen_done=1 latches mine into board -> PLAY. No timeout.
- PLAY: act_ready=1, playing=1. Handshake = act_valid & act_ready; act_type and act_pos are latched on it.
  - Flag, cell not revealed: toggle flagged[pos]; stay PLAY.
  - Flag, cell revealed: no effect.
  - Reveal, cell flagged or already revealed: no effect; stay PLAY.
  - Reveal, board[pos]=1: set revealed[pos]; -> LOSE. No rev_valid.
  - Reveal, otherwise: clear accumulator; -> SCAN.
- SCAN: exactly 8 cycles, index k=0..7 over offsets (-1,-1),(-1,0),(-1,+1),(0,-1),(0,+1),(+1,-1),(+1,0),(+1,+1) as (drow,dcol).
  - Neighbours outside 0..7 in either row or column are skipped; there is no wrap-around.
  - Accumulator += board[neighbour]. 4-bit, max 8.
- REVEAL (1 cycle): rev_valid=1, rev_pos=pos, rev_cnt=accumulator. Set revealed[pos]; revealed-counter +1.
  - If the new count == 64-MINES -> WIN, else -> PLAY.
- Timing: handshake in cycle c, SCAN in c+1..c+8, rev_valid in c+9. revealed bit and act_ready are visible in c+10.
- No flood fill: a 0-count cell reveals only itself.
- WIN: won=1. LOSE: lost=1. In both, act_ready=0 and the bitmaps are held until new_game.
- Reset asserted mid-SCAN/GEN_WAIT: immediate return to IDLE with all reset values.

Test Plan:
- Reset then new_game -> gen_reset high for exactly 1 cycle. gen_done held 1 from before is not accepted in the first 2 GEN_WAIT cycles. A later gen_done -> playing=1, act_ready=1.
- Mines {1,8,9}; reveal pos 0 -> rev_valid 9 cycles after handshake, rev_pos=0, rev_cnt=3, revealed[0]=1.
- Mines {0,7,56,63}, reveal 9 -> cnt 1. Reveal 62 -> cnt 1; edge wrap must not count 55/7. Reveal 27 with all 8 neighbours mined -> cnt 8.
- Flag pos 5, then reveal pos 5 -> no state change. Flag again -> flagged[5]=0. Flag a revealed cell -> ignored.
- Reveal a mine cell -> lost=1, revealed[pos]=1, no rev_valid, act_ready=0. Then new_game -> bitmaps cleared.
- MINES=9: reveal all 55 safe cells -> won=1 on the 55th REVEAL. new_game and act_valid in the same PLAY cycle -> restart, action dropped.
